// File: rtl/subtracting_bytes_serial_pkg.sv
// Shared arithmetic-group constants and the serial subtractor state encoding.
package arith_pkg;

    localparam int BYTE_W    = 8;
    localparam int BIT_CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

endpackage

// File: rtl/subtracting_bytes_serial_fa.sv
// Single-bit full adder shared by the arithmetic group: out = in0^in1^in2, cout = majority.
module FULL_ADDER (
    input  logic in0,
    input  logic in1,
    input  logic in2,
    output logic out,
    output logic cout
);

    assign out  = in0 ^ in1 ^ in2;
    assign cout = (in0 & in1) | (in0 & in2) | (in1 & in2);

endmodule

// File: rtl/subtracting_bytes_serial.sv
// Bit-serial 8-bit subtractor (in0 - in1 - bin), LSB first through one full-adder cell.
// Optional signed-overflow output enabled by defining SUBTRACTING_BYTES_OVF_EN.
module subtracting_bytes_serial
    import arith_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BYTE_W-1:0] in0,
    input  logic [BYTE_W-1:0] in1,
    input  logic              bin,
    output logic              busy,
    output logic              done,
    output logic [BYTE_W-1:0] out,
    output logic              borrow
`ifdef SUBTRACTING_BYTES_OVF_EN
    ,
    output logic              ovf
`endif
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(BYTE_W - 1);

    sub_state_t           state_q;
    logic [BIT_CNT_W-1:0] cnt_q;
    logic                 carry_q;
    logic [BYTE_W-1:0]    opa_q;
    logic [BYTE_W-1:0]    opb_q;
    logic [BYTE_W-1:0]    res_q;
    logic [BYTE_W-1:0]    res_d;
    logic                 busy_q;
    logic                 done_q;
    logic [BYTE_W-1:0]    out_q;
    logic                 borrow_q;

    logic                 opa_bit;
    logic                 opb_bit;
    logic                 opb_inv;
    logic                 fa_sum;
    logic                 fa_cout;
    logic                 accept;

    assign opa_bit = opa_q[cnt_q];
    assign opb_bit = opb_q[cnt_q];
    assign opb_inv = ~opb_bit;

    // a - b - bin == a + ~b + ~bin; the carry register holds the inverted borrow.
    FULL_ADDER u_fa (
        .in0  (carry_q),
        .in1  (opa_bit),
        .in2  (opb_inv),
        .out  (fa_sum),
        .cout (fa_cout)
    );

    assign res_d  = {fa_sum, res_q[BYTE_W-1:1]};
    assign accept = !rst && start && (state_q == IDLE || state_q == DONE);

    always_ff @(posedge clk) begin
        if (accept) begin
            opa_q <= in0;
            opb_q <= in1;
            res_q <= '0;
        end else if (state_q == RUN) begin
            res_q <= res_d;
        end
    end

`ifdef SUBTRACTING_BYTES_OVF_EN
    logic ovf_q;
    assign ovf = ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            out_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
`ifdef SUBTRACTING_BYTES_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        carry_q <= ~bin;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    carry_q <= fa_cout;
                    cnt_q   <= cnt_q + 1'b1;
                    // Results are published only here so outputs never show partial sums.
                    if (cnt_q == LAST_BIT) begin
                        state_q  <= DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        out_q    <= res_d;
                        borrow_q <= ~fa_cout;
`ifdef SUBTRACTING_BYTES_OVF_EN
                        ovf_q    <= (opa_bit ^ opb_bit) & (opa_bit ^ fa_sum);
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign out    = out_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_subtracting_bytes_serial.sv
// Scoreboard bench for subtracting_bytes_serial: driver queues expected results, monitor checks on done.
module tb_subtracting_bytes_serial;

    typedef struct {
        logic [7:0] out;
        logic       brw;
        logic       ovf;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] in0;
    logic [7:0] in1;
    logic       bin;
    logic       busy;
    logic       done;
    logic [7:0] out;
    logic       borrow;
`ifdef SUBTRACTING_BYTES_OVF_EN
    logic       ovf;
`endif

    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t q[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    subtracting_bytes_serial dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .in0    (in0),
        .in1    (in1),
        .bin    (bin),
        .busy   (busy),
        .done   (done),
        .out    (out),
        .borrow (borrow)
`ifdef SUBTRACTING_BYTES_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic bi);
        exp_t       e;
        logic [8:0] d;
        int         s;
        d = {1'b0, a} - {1'b0, b} - {8'd0, bi};
        s = int'($signed(a)) - int'($signed(b)) - (bi ? 1 : 0);
        e.out = d[7:0];
        e.brw = d[8];
        e.ovf = (s < -128) || (s > 127);
        e.due = 0;
        return e;
    endfunction

    task automatic push_exp(input logic [7:0] eo, input logic eb, input logic eov);
        exp_t e;
        e.out = eo;
        e.brw = eb;
        e.ovf = eov;
        e.due = cyc + 8;
        q.push_back(e);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bi,
                          input logic [7:0] eo, input logic eb, input logic eov);
        @(negedge clk);
        start = 1'b1; in0 = a; in1 = b; bin = bi;
        @(negedge clk);
        start = 1'b0;
        push_exp(eo, eb, eov);
        chk("busy_after_accept", busy, 1);
        repeat (8) @(negedge clk);
        chk("busy_in_done", busy, 0);
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no result pending (cycle %0d)", cyc);
            end else begin
                mon_e = q.pop_front();
                chk("out", out, mon_e.out);
                chk("borrow", borrow, mon_e.brw);
`ifdef SUBTRACTING_BYTES_OVF_EN
                chk("ovf", ovf, mon_e.ovf);
`endif
                chk("done_cycle", cyc, mon_e.due);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, got cycle %0d expected finish", cyc);
        $fatal(1, "timeout");
    end

    logic [7:0] dv_a  [8] = '{8'h05, 8'h00, 8'h10, 8'h80, 8'h7F, 8'h00, 8'hFF, 8'h80};
    logic [7:0] dv_b  [8] = '{8'h03, 8'h01, 8'h0F, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h00};
    logic       dv_bi [8] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b1,  1'b1,  1'b1};
    logic [7:0] dv_o  [8] = '{8'h02, 8'hFF, 8'h00, 8'h7F, 8'h7F, 8'hFF, 8'hFE, 8'h7F};
    logic       dv_br [8] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0};
    logic       dv_ov [8] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1};

    initial begin
        exp_t       e;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rbi;

        rst = 1'b1; start = 1'b0; in0 = '0; in1 = '0; bin = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out", out, 0);
        chk("rst_borrow", borrow, 0);
`ifdef SUBTRACTING_BYTES_OVF_EN
        chk("rst_ovf", ovf, 0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            run_op(dv_a[i], dv_b[i], dv_bi[i], dv_o[i], dv_br[i], dv_ov[i]);

        // start during RUN is ignored; start held into DONE launches the next operation
        @(negedge clk);
        start = 1'b1; in0 = 8'h20; in1 = 8'h01; bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        push_exp(8'h1F, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        start = 1'b1; in0 = 8'hFF; in1 = 8'hFF; bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("busy_ignored_start", busy, 1);
        repeat (3) @(negedge clk);
        start = 1'b1; in0 = 8'h09; in1 = 8'h04; bin = 1'b0;
        @(negedge clk);
        chk("done_b2b", done, 1);
        @(negedge clk);
        start = 1'b0;
        push_exp(8'h05, 1'b0, 1'b0);
        chk("busy_b2b", busy, 1);
        repeat (8) @(negedge clk);
        @(negedge clk);

        // reset mid-RUN aborts without a done
        start = 1'b1; in0 = 8'hAA; in1 = 8'h55; bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_out", out, 0);
        chk("abort_borrow", borrow, 0);
        repeat (12) @(negedge clk);

        // start with rst: reset wins
        rst = 1'b1; start = 1'b1; in0 = 8'h33; in1 = 8'h11;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_start_busy", busy, 0);
        repeat (12) @(negedge clk);
        chk("rst_start_idle", busy, 0);

        for (int i = 0; i < 1000; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rbi = 1'($urandom);
            e   = model(ra, rb, rbi);
            run_op(ra, rb, rbi, e.out, e.brw, e.ovf);
        end

        repeat (5) @(negedge clk);
        chk("pending_results", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/subtracting_bytes_serial.md
# subtracting_bytes_serial

Bit-serial 8-bit subtractor computing `in0 - in1 - bin` one bit per clock, LSB first, through a single full-adder cell. It is the inverse-direction companion to the combinational byte adder in the arithmetic group. It trades an 8-cycle latency for one adder cell. It accepts operands on a start pulse, reports `busy`, and presents the result with a one-cycle `done` strobe.

## Interface
- Parameters: none; width is fixed at 8 by package constant `BYTE_W`.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  operand-capture request; honoured only in IDLE or DONE
- `in0`  in  8  minuend, sampled on accepted `start`
- `in1`  in  8  subtrahend, sampled on accepted `start`
- `bin`  in  1  borrow-in, sampled on accepted `start`
- `busy`  out  1  high while in RUN
- `done`  out  1  one-cycle strobe: `out`/`borrow` valid
- `out`  out  8  difference, `(in0 - in1 - bin) mod 256`
- `borrow`  out  1  borrow-out; 1 when `in0 < in1 + bin` (unsigned)
- `ovf`  out  1  signed overflow; present only with `SUBTRACTING_BYTES_OVF_EN`

## Operation
- Subtraction is done as addition. Each step feeds the full-adder `a = opa[k]`, `b = ~opb[k]`, `cin = carry`.
- The carry register is initialised to `~bin` on start. Final `borrow = ~carry` after bit 7.
- FSM states are IDLE, RUN, DONE.
  - IDLE: on `start`, latch `in0`, `in1` and `bin`, clear the bit counter, clear the result shift register, then go to RUN.
  - RUN: each cycle computes bit `k` and shifts the sum bit into result bit `k`. The counter increments. After `k = 7`, go to DONE.
  - DONE: `done` = 1 for exactly this cycle. Next state is RUN if `start` is high (back-to-back operation, new operands latched), otherwise IDLE.
- `start` in RUN is ignored; operands are not re-latched.
- `out`, `borrow` and `ovf` update only at the RUN→DONE edge. They hold until the next RUN→DONE edge and do not show partial results.
- Reset values: state IDLE, `busy` 0, `done` 0, `out` 0x00, `borrow` 0, `ovf` 0, counter 0, carry 0.
- Reset asserted mid-RUN aborts the operation. No `done` is produced, and outputs return to reset values on that edge.
- `start` asserted together with `rst`: reset wins and `start` is dropped.

## Timing
- Edge E0 samples `start` high in IDLE. `busy` = 1 from E0 through E8.
- Edges E1..E8 process bits 0..7.
- After E8, state is DONE: `done` = 1 and results are valid in the cycle following E8.
- Latency is 9 clocks from the accepting edge to the `done` cycle. Throughput is one result per 9 clocks when `start` is held or re-pulsed in DONE.
- There are no combinational paths from inputs to outputs; all outputs are registered.

## Configuration
- Macro: `SUBTRACTING_BYTES_OVF_EN`.
- Defined: port `ovf` exists. It is registered at the RUN→DONE edge as `opa[7] ^ opb[7]) & (opa[7] ^ out[7])`, i.e. two's-complement overflow of `in0 - in1 - bin`. It is reset to 0.
- Undefined: no `ovf` port and no associated logic. All other behaviour is identical.

## Structure
- Shared package `arith_pkg` holds:
  - `BYTE_W = 8`
  - `BIT_CNT_W = 3`
  - enum `sub_state_t` {IDLE, RUN, DONE}
- Sub-module: one instance of the existing `FULL_ADDER` (ports `in0`, `in1`, `in2` → `out`, `cout`). Wire them as `in0` = carry, `in1` = `opa[k]`, `in2` = `~opb[k]`.
- The operand registers may shift right each RUN cycle instead of being indexed by the counter; either implementation is acceptable.

## Test plan
- `in0`=0x05, `in1`=0x03, `bin`=0, start at E0 → `done` only in the cycle after E8; `out`=0x02, `borrow`=0, `ovf`=0.
- `in0`=0x00, `in1`=0x01, `bin`=0 → `out`=0xFF, `borrow`=1, `ovf`=0. Then `in0`=0x10, `in1`=0x0F, `bin`=1 → `out`=0x00, `borrow`=0.
- `in0`=0x80, `in1`=0x01, `bin`=0 → `out`=0x7F, `borrow`=0, `ovf`=1 (macro defined; port absent when undefined).
- Start 0x20−0x01; at E4 apply a different `start` with 0xFF−0xFF → ignored, result 0x1F. Hold `start` high with 0x09−0x04 during DONE → next result 0x05 exactly 9 clocks later.
- Start 0xAA−0x55; assert `rst` at E5 → all outputs 0 the next cycle, no `done` ever. `start` and `rst` together → stays IDLE.
- Random sweep of 1000 operand/`bin` triples against the behavioural model `{borrow,out} = in0 - in1 - bin` (9-bit), with `ovf` checked when enabled.
